// File: rtl/conv_engine_if.sv
// conv_engine_if
// Bundles the two bus-like port groups of conv_engine:
//   - memory read port: mem_rd / mem_addr out, mem_data back (one-cycle latency)
//   - result stream:    out_data / out_addr / out_valid out, out_ready back
// master = engine side, slave = memory model + downstream consumer.
interface conv_engine_if #(
    parameter int DW      = 8,
    parameter int ADDR_W  = 10,
    parameter int OADDR_W = 10
);
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic signed [DW-1:0]      mem_data;
    logic signed [DW-1:0]      out_data;
    logic [OADDR_W-1:0]        out_addr;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mem_rd, mem_addr, out_data, out_addr, out_valid,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_data, out_addr, out_valid,
        output mem_data, out_ready
    );
endinterface

// File: rtl/conv_engine.sv
// conv_engine
// Parametrised single-channel 2D convolution: one memory read and one MAC per
// cycle, result requantised (shift, optional ReLU, saturate) and offered on a
// valid/ready port.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a feature map (IDLE only); latches kernel and bias
//   kernel      K*K signed taps, tap r*K+c at [(r*K+c)*DW +: DW]
//   bias        signed accumulator preload
//   bus         conv_engine_if.master: memory read port and result stream
//   busy        high while a map is in progress
//   done        one-cycle pulse after the last result handshake
module conv_engine #(
    parameter int DW      = 8,
    parameter int H       = 28,
    parameter int W       = 28,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int PAD     = 0,
    parameter int ACC_W   = 20,
    parameter int SHIFT   = 0,
    parameter int RELU    = 1,
    parameter int ADDR_W  = 10,
    parameter int OADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K*K*DW-1:0]       kernel,
    input  logic signed [ACC_W-1:0] bias,
    conv_engine_if.master           bus,
    output logic                    busy,
    output logic                    done
);
    localparam int OH = (H + 2*PAD - K) / STRIDE + 1;
    localparam int OW = (W + 2*PAD - K) / STRIDE + 1;
    localparam int NT = K * K;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int CW = (ADDR_W > 16) ? ADDR_W : 16;
    localparam int SW = CW + 1;

    localparam logic signed [SW-1:0]    STR_S = SW'(STRIDE);
    localparam logic signed [SW-1:0]    PAD_S = SW'(PAD);
    localparam logic signed [SW-1:0]    H_S   = SW'(H);
    localparam logic signed [SW-1:0]    W_S   = SW'(W);
    localparam logic [CW-1:0]           W_U   = CW'(W);
    localparam logic [CW-1:0]           OW_U  = CW'(OW);
    localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'((2**(DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV  = ACC_W'(-(2**(DW-1)));

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUTPUT, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [DW-1:0]      k_q [NT];
    logic signed [ACC_W-1:0]   bias_q, acc_q;
    logic [CW-1:0]             oy, ox, ky, kx;
    logic [TW-1:0]             tap_q, rtap_q;
    logic                      pend_q;
    logic [ADDR_W-1:0]         addr_q;

    logic signed [SW-1:0]      iy, ix;
    logic                      in_b;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   acc_sum, shifted;
    logic signed [DW-1:0]      res;
    logic                      last_tap, last_pix;

    // Tap coordinates in the unpadded image; negative or >= size means padding.
    always_comb begin
        iy      = $signed({1'b0, oy}) * STR_S + $signed({1'b0, ky}) - PAD_S;
        ix      = $signed({1'b0, ox}) * STR_S + $signed({1'b0, kx}) - PAD_S;
        in_b    = !iy[SW-1] && (iy < H_S) && !ix[SW-1] && (ix < W_S);
        rd_addr = ADDR_W'(iy[CW-1:0] * W_U + ix[CW-1:0]);
    end

    // mem_data belongs to the read issued last cycle; pend_q/rtap_q track it.
    always_comb begin
        prod    = bus.mem_data * k_q[rtap_q];
        acc_sum = acc_q + (pend_q ? ACC_W'(prod) : '0);
        shifted = acc_sum >>> SHIFT;
        if (RELU != 0 && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        if (shifted > MAXV) begin
            res = DW'(MAXV);
        end else if (shifted < MINV) begin
            res = DW'(MINV);
        end else begin
            res = shifted[DW-1:0];
        end
    end

    assign last_tap = (ky == CW'(K - 1)) && (kx == CW'(K - 1));
    assign last_pix = (oy == CW'(OH - 1)) && (ox == CW'(OW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = addr_q;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                bus.mem_rd = in_b;
                if (in_b) bus.mem_addr = rd_addr;
                if (last_tap) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = last_pix ? DONE : FETCH;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < NT; t++) k_q[t] <= '0;
            bias_q       <= '0;
            acc_q        <= '0;
            oy           <= '0;
            ox           <= '0;
            ky           <= '0;
            kx           <= '0;
            tap_q        <= '0;
            rtap_q       <= '0;
            pend_q       <= 1'b0;
            addr_q       <= '0;
            bus.out_data <= '0;
            bus.out_addr <= '0;
        end else begin
            pend_q <= (state_q == FETCH) && in_b;
            rtap_q <= tap_q;
            if (state_q == FETCH && in_b) addr_q <= rd_addr;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int unsigned t = 0; t < NT; t++) k_q[t] <= kernel[t*DW +: DW];
                        bias_q <= bias;
                        acc_q  <= bias;
                        oy     <= '0;
                        ox     <= '0;
                        ky     <= '0;
                        kx     <= '0;
                        tap_q  <= '0;
                    end
                end
                FETCH: begin
                    acc_q <= acc_sum;
                    tap_q <= tap_q + TW'(1);
                    if (kx == CW'(K - 1)) begin
                        kx <= '0;
                        ky <= ky + CW'(1);
                    end else begin
                        kx <= kx + CW'(1);
                    end
                end
                DRAIN: begin
                    acc_q        <= acc_sum;
                    bus.out_data <= res;
                    bus.out_addr <= OADDR_W'(oy * OW_U + ox);
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        if (!last_pix) begin
                            if (ox == CW'(OW - 1)) begin
                                ox <= '0;
                                oy <= oy + CW'(1);
                            end else begin
                                ox <= ox + CW'(1);
                            end
                        end
                        ky    <= '0;
                        kx    <= '0;
                        tap_q <= '0;
                        acc_q <= bias_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/conv_engine.md
# conv_engine

Parametrised successor to the fixed 3x3 convolution datapath. It computes one output feature map from one input channel held in external single-port memory. Kernel size, stride, zero-padding, data width, accumulator width, bias, requantisation shift and optional ReLU are all set by parameters. It issues one memory read and one MAC per cycle, and presents each result on a valid/ready output port that the downstream store or pooling stage consumes.

## Interface
- DW, 8: signed pixel, kernel and output width.
- H, 28 / W, 28: input height and width.
- K, 3: kernel size (K x K), K >= 1.
- STRIDE, 1: stride in both dimensions.
- PAD, 0: zero-padding on every border; padded taps contribute 0.
- ACC_W, 20: signed accumulator width.
- SHIFT, 0: arithmetic right shift applied before saturation.
- RELU, 1: 1 clamps negative results to 0.
- ADDR_W, 10 / OADDR_W, 10: input and output address widths.
- Derived: OH = (H+2*PAD-K)/STRIDE+1, OW = (W+2*PAD-K)/STRIDE+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a feature map; sampled only in IDLE.
- kernel  in  K*K*DW  signed taps; tap r*K+c occupies bits [(r*K+c)*DW +: DW]. Latched on start.
- bias  in  ACC_W  signed bias, latched on start.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_W  row-major address y*W+x.
- mem_data  in  DW  signed read data, valid exactly one cycle after mem_rd.
- out_data  out  DW  requantised result.
- out_addr  out  OADDR_W  oy*OW+ox.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last output handshake.

## Operation
- FSM states are IDLE, FETCH, DRAIN, OUTPUT, DONE.
- IDLE, start=1: latch kernel and bias, set oy=ox=0, set ky=kx=0, acc<=bias, go to FETCH.
- FETCH: one tap per cycle at iy=oy*STRIDE+ky-PAD, ix=ox*STRIDE+kx-PAD.
  - In-bounds tap: mem_rd=1.
  - Out-of-bounds tap: mem_rd=0, mem_addr holds its previous value, and the tap contributes 0. The cycle is still spent.
  - Taps advance kx first, then ky. After tap K*K-1, go to DRAIN.
- Accumulation: mem_data*kernel[tap] is sign-extended and added to acc on the cycle after the read. There is no overflow detection; acc wraps at ACC_W.
- DRAIN: add the final product, compute the result, register it into out_data and out_addr, go to OUTPUT.
- Result rule: r = acc >>> SHIFT. If RELU and r<0, r=0. Then saturate to [-2^(DW-1), 2^(DW-1)-1].
- OUTPUT: out_valid=1. out_data and out_addr are held stable until out_valid&&out_ready. On handshake:
  - Last pixel (oy=OH-1, ox=OW-1): go to DONE.
  - Otherwise: advance ox, wrapping to 0 and incrementing oy. Reset ky and kx, set acc<=bias, go to FETCH.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored in every state except IDLE. Changing kernel or bias inputs while busy has no effect.
- Reset, including mid-operation, forces IDLE and clears all counters and acc.

## Timing
- Reset values: mem_rd=0, mem_addr=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0.
- Start accepted at edge E0: busy=1 and the first tap's mem_rd appear in the cycle after E0.
- Per output pixel, K*K FETCH cycles + 1 DRAIN cycle, then OUTPUT. out_valid rises K*K+1 cycles after FETCH entry.
- With out_ready held at 1, throughput is K*K+2 cycles per output pixel.
- Backpressure: no mem_rd while in OUTPUT or DONE. acc is frozen.
- A handshake in the same cycle out_valid first rises is legal. The next FETCH cycle follows immediately.
- done rises the cycle after the final handshake. busy falls in that same cycle.
- A full map takes OH*OW*(K*K+2)+1 cycles from the start edge when out_ready is held at 1.

## Test plan
- Identity kernel (center tap=1, others 0), K=3, H=W=4, ramp image p=y*4+x, PAD=0: 4 outputs in order 5,6,9,10 at out_addr 0..3. done pulses once, 4*11+1 cycles after start.
- Saturation, all pixels 127 and all taps 127, SHIFT=0: output 127. With pixels -128, RELU=1: output 0. With pixels -128, RELU=0: output -128.
- PAD=1, K=3, H=W=4, all-ones image and kernel: 16 outputs. Corner pixel has exactly 4 mem_rd pulses and outputs 4; edge pixel outputs 6; interior pixel outputs 9.
- STRIDE=2, H=W=5, K=3: OH=OW=2. Read addresses for pixel (1,1) start at 12.
- Backpressure: hold out_ready=0 for 5 cycles during OUTPUT. out_data and out_addr stay constant, mem_rd stays 0, and the next pixel is correct after release.
- Reset asserted mid-FETCH: all outputs return to reset values immediately. A second start is ignored while busy, and a fresh start after reset produces the correct full map.
